// File: rtl/ripple_add_sequencer_if.sv
// ripple_add_sequencer_if
// Groups the operand request and result handshakes of ripple_add_sequencer.
//
// Parameters:
//   NIBBLES   number of 4-bit slices per operand (W = 4*NIBBLES)
// Signals:
//   in_valid / in_ready     operand handshake (requester -> block)
//   a, b, c_in              operands and carry into nibble 0
//   sub                     subtract select, only with RIPPLE_ADD_SEQUENCER_SUB_EN
//   out_valid / out_ready   result handshake (block -> consumer)
//   sum, c_out              result and carry out of the top nibble
//   busy                    block is running or holding a result
// Modports: master = requester/consumer side, slave = the sequencer.
// Configuration macro: RIPPLE_ADD_SEQUENCER_SUB_EN adds the sub signal.

interface ripple_add_sequencer_if #(
    parameter int unsigned NIBBLES = 4
);
    localparam int unsigned W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
`ifdef RIPPLE_ADD_SEQUENCER_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         busy;

`ifdef RIPPLE_ADD_SEQUENCER_SUB_EN
    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, busy
    );
    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, busy
    );
`else
    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, busy
    );
    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, busy
    );
`endif

endinterface

// File: rtl/ripple_add_sequencer.sv
// ripple_add_sequencer
// W-bit adder built from a single 4-bit add slice, evaluated once per RUN cycle,
// least-significant nibble first. A job takes exactly NIBBLES RUN cycles; the
// result is then held with out_valid until the consumer takes it.
//
// Parameters:
//   NIBBLES   4-bit slices per operand, 1..16 (W = 4*NIBBLES)
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   bus       ripple_add_sequencer_if.slave (operand and result handshakes)
// Configuration macro: RIPPLE_ADD_SEQUENCER_SUB_EN enables A-B via bus.sub
// (B is inverted and the carry-in forced to 1; c_out=1 then means no borrow).

module ripple_add_sequencer #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ripple_add_sequencer_if.slave bus
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] KLast = KW'(NIBBLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic          c_out_q, c_out_d;
    logic [KW-1:0] k_q, k_d;

    logic [KW+1:0] shamt;
    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [4:0]    slice;
    logic          last_nib;
    logic [W-1:0]  nib_mask;

    // Bit offset of nibble k is 4*k.
    assign shamt    = {k_q, 2'b00};
    assign a_nib    = 4'(a_q >> shamt);
    assign b_nib    = 4'(b_q >> shamt);
    assign slice    = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
    assign last_nib = (k_q == KLast);
    assign nib_mask = W'(4'hF) << shamt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            k_q     <= k_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.in_valid)  state_d = StRun;
            StRun:   if (last_nib)      state_d = StDone;
            StDone:  if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state: operands only load on accept, so in_valid outside
    // IDLE cannot disturb a running job.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        k_d     = k_q;
        if (state_q == StIdle && bus.in_valid) begin
            a_d = bus.a;
            k_d = '0;
`ifdef RIPPLE_ADD_SEQUENCER_SUB_EN
            b_d     = bus.sub ? ~bus.b : bus.b;
            carry_d = bus.sub | bus.c_in;
`else
            b_d     = bus.b;
            carry_d = bus.c_in;
`endif
        end else if (state_q == StRun) begin
            sum_d   = (sum_q & ~nib_mask) | (W'(slice[3:0]) << shamt);
            carry_d = slice[4];
            k_d     = last_nib ? '0 : k_q + 1'b1;
            if (last_nib) begin
                c_out_d = slice[4];
            end
        end
    end

    // Outputs
    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StDone);
        bus.busy      = (state_q != StIdle);
        bus.sum       = sum_q;
        bus.c_out     = c_out_q;
    end

endmodule

// File: tb/tb_ripple_add_sequencer.sv
// tb_ripple_add_sequencer
// Self-checking bench for ripple_add_sequencer (NIBBLES=4): directed vector table,
// hand-written handshake/reset sequences and randomized jobs against an
// arithmetic reference model.

module tb_ripple_add_sequencer;

    localparam int unsigned NIB = 4;
    localparam int unsigned W   = 4 * NIB;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        int           hold;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    ripple_add_sequencer_if #(.NIBBLES(NIB)) bus ();

    ripple_add_sequencer #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sub(input logic s);
`ifdef RIPPLE_ADD_SEQUENCER_SUB_EN
        bus.sub = s;
`else
        if (s) $display("note: sub requested but not built in");
`endif
    endtask

    // Reference: plain arithmetic on whole operands, returns {c_out, sum}.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic s);
        logic [W:0] r;
        if (s) begin
            r = {(a >= b), W'(a - b)};
        end else begin
            r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                input logic s, input int hold, input logic [W-1:0] es,
                                input logic ec);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.sub = s; v.hold = hold;
        v.exp_sum = es; v.exp_cout = ec;
        return v;
    endfunction

    // Wait for a result with a bounded budget; returns cycles waited.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic run_job(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic s, input int hold,
                           input logic [W-1:0] exp_sum, input logic exp_cout);
        int lat;
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            step();
            n++;
        end
        check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.c_in      = cin;
        set_sub(s);
        // With hold==0 out_ready is already high during RUN, where it must do nothing.
        bus.out_ready = (hold == 0);
        step();
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.c_in     = 1'($urandom);
        check({tag, " busy"}, 64'(bus.busy), 64'd1);
        check({tag, " in_ready in run"}, 64'(bus.in_ready), 64'd0);
        wait_valid(lat);
        check({tag, " latency"}, 64'(lat), 64'(NIB));
        check({tag, " sum"}, 64'(bus.sum), 64'(exp_sum));
        check({tag, " c_out"}, 64'(bus.c_out), 64'(exp_cout));
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, " held valid"}, 64'(bus.out_valid), 64'd1);
            check({tag, " held sum"}, 64'(bus.sum), 64'(exp_sum));
            check({tag, " held c_out"}, 64'(bus.c_out), 64'(exp_cout));
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, " valid dropped"}, 64'(bus.out_valid), 64'd0);
        check({tag, " idle"}, 64'(bus.busy), 64'd0);
        check({tag, " sum kept"}, 64'(bus.sum), 64'(exp_sum));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t       vecs[$];
        logic [W:0] r;
        int         lat;

        vecs.push_back(mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 1'b1));
        vecs.push_back(mk(16'h1234, 16'h4321, 1'b1, 1'b0, 5, 16'h5556, 1'b0));
        vecs.push_back(mk(16'h0000, 16'h0000, 1'b0, 1'b0, 0, 16'h0000, 1'b0));
        vecs.push_back(mk(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 2, 16'hFFFF, 1'b1));
        vecs.push_back(mk(16'h8000, 16'h8000, 1'b0, 1'b0, 1, 16'h0000, 1'b1));
        vecs.push_back(mk(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 0, 16'h1000, 1'b0));
`ifdef RIPPLE_ADD_SEQUENCER_SUB_EN
        vecs.push_back(mk(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 16'hFFFE, 1'b0));
        vecs.push_back(mk(16'h0007, 16'h0005, 1'b0, 1'b1, 0, 16'h0002, 1'b1));
        vecs.push_back(mk(16'h1234, 16'h1234, 1'b1, 1'b1, 1, 16'h0000, 1'b1));
`endif

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c_in      = 1'b0;
        bus.out_ready = 1'b0;
        set_sub(1'b0);
        step();
        step();
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset sum", 64'(bus.sum), 64'd0);
        check("reset c_out", 64'(bus.c_out), 64'd0);
        rst_n = 1'b1;
        #1;
        check("reset in_ready", 64'(bus.in_ready), 64'd1);
        step();

        foreach (vecs[i]) begin
            run_job($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                    vecs[i].hold, vecs[i].exp_sum, vecs[i].exp_cout);
        end

        // in_valid during RUN is ignored; held in_valid at release is not accepted
        // on the release edge but on the following one.
        bus.a = 16'h000F; bus.b = 16'h0001; bus.c_in = 1'b0; set_sub(1'b0);
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        bus.in_valid = 1'b1; bus.a = 16'hAAAA;
        check("ignore in_ready", 64'(bus.in_ready), 64'd0);
        wait_valid(lat);
        check("ignore latency", 64'(lat), 64'd3);
        check("ignore sum", 64'(bus.sum), 64'h0010);
        check("ignore c_out", 64'(bus.c_out), 64'd0);
        step();
        check("gap busy", 64'(bus.busy), 64'd0);
        check("gap in_ready", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        check("gap accept", 64'(bus.busy), 64'd1);
        wait_valid(lat);
        check("gap sum", 64'(bus.sum), 64'hAAAB);
        step();
        bus.out_ready = 1'b0;

        // Reset in the middle of RUN abandons the job immediately.
        bus.a = 16'h00FF; bus.b = 16'h0F01; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("rst run out_valid", 64'(bus.out_valid), 64'd0);
        check("rst run sum", 64'(bus.sum), 64'd0);
        check("rst run c_out", 64'(bus.c_out), 64'd0);
        check("rst run busy", 64'(bus.busy), 64'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("rst run in_ready", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < NIB + 2; i++) begin
            step();
            check("rst run no pulse", 64'(bus.out_valid), 64'd0);
        end
        run_job("after rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 0, 16'h0002, 1'b0);

        // Reset while a result is waiting in DONE.
        bus.a = 16'h7000; bus.b = 16'h9000; bus.c_in = 1'b0; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check("done sum", 64'(bus.sum), 64'h0000);
        check("done c_out", 64'(bus.c_out), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst done out_valid", 64'(bus.out_valid), 64'd0);
        check("rst done busy", 64'(bus.busy), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        check("rst done stays idle", 64'(bus.out_valid), 64'd0);

        // Randomized jobs against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            logic         rs;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
`ifdef RIPPLE_ADD_SEQUENCER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            r = model(ra, rb, rc, rs);
            run_job($sformatf("rand%0d", i), ra, rb, rc, rs, int'($urandom_range(0, 3)),
                    r[W-1:0], r[W]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ripple_add_sequencer.md
RIPPLE_ADD_SEQUENCER -- requirements
Module: ripple_add_sequencer

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices per operand (legal 1..16).
REQ-002 Operand width W SHALL equal 4*NIBBLES bits.
REQ-003 clk  input  1  single clock; all state SHALL change on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  requester presents an operand pair.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  W  operand A.
REQ-008 b  input  W  operand B.
REQ-009 c_in  input  1  carry into nibble 0.
REQ-010 sub  input  1  present only with SUB_EN; 1 selects A-B.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes the result this cycle.
REQ-013 sum  output  W  result.
REQ-014 c_out  output  1  carry out of the top nibble.
REQ-015 busy  output  1  high in RUN or DONE.

Function
REQ-016 The block SHALL compute a W-bit add using one 4-bit add slice (a+b+c, 4-bit sum, carry) evaluated once per RUN cycle, least-significant nibble first.
REQ-017 FSM states SHALL be IDLE, RUN and DONE.
REQ-018 IDLE: in_ready=1; on in_valid=1, latch a, b and the carry-in (plus sub), clear nibble counter k to 0, go to RUN.
REQ-019 RUN: in_ready=0; each cycle add nibble k of A and B with carry register, write sum nibble k, store slice carry into carry register, k=k+1.
REQ-020 RUN SHALL exit to DONE on the edge that processes nibble NIBBLES-1; RUN therefore lasts exactly NIBBLES cycles.
REQ-021 out_valid SHALL rise NIBBLES cycles after the accepting edge and SHALL remain high with sum and c_out stable until out_ready=1.
REQ-022 DONE with out_ready=1: drop out_valid and go to IDLE on that edge; a new accept SHALL NOT occur in the same cycle (minimum 1 IDLE cycle between jobs).
REQ-023 in_valid during RUN or DONE SHALL be ignored; latched operands SHALL NOT change.
REQ-024 c_out SHALL equal the carry from nibble NIBBLES-1; sum SHALL equal (A+B+cin) mod 2^W.
REQ-025 out_ready while out_valid=0 SHALL have no effect.
REQ-026 sum SHALL hold its last result in IDLE until overwritten by the next job's RUN cycles.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, k=0, carry register=0, sum=0, c_out=0, out_valid=0, busy=0; in_ready SHALL be 1 as soon as rst_n=1.
REQ-028 Reset asserted mid-RUN or in DONE SHALL abandon the job with no out_valid pulse.

Configuration
REQ-029 Macro RIPPLE_ADD_SEQUENCER_SUB_EN SHALL enable subtraction.
REQ-030 With the macro defined: sub port exists; sub=1 at accept SHALL latch ~b as B and force carry-in to 1, ignoring c_in; c_out=1 SHALL mean no borrow.
REQ-031 Without the macro: no sub port; the block SHALL always add A+B+c_in.

Verification (NIBBLES=4)
REQ-032 a=0xFFFF, b=0x0001, c_in=0, out_ready=1 -> out_valid 4 cycles after accept, sum=0x0000, c_out=1, then IDLE.
REQ-033 a=0x1234, b=0x4321, c_in=1, out_ready=0 for 5 cycles after out_valid -> out_valid held, sum=0x5556, c_out=0 stable throughout; released on out_ready=1.
REQ-034 Accept a=0x000F, b=0x0001; at RUN cycle 2 drive in_valid=1 with a=0xAAAA -> ignored, in_ready=0, result sum=0x0010, c_out=0.
REQ-035 Accept job, deassert rst_n at RUN cycle 2 -> out_valid, sum, c_out, busy all 0 immediately; after release, in_ready=1 and next job 0x0001+0x0001 gives 0x0002.
REQ-036 With SUB_EN: a=0x0005, b=0x0007, sub=1, c_in=0 -> sum=0xFFFE, c_out=0; a=0x0007, b=0x0005, sub=1 -> sum=0x0002, c_out=1.
